// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving two requesters fixed-latency line bursts to one memory.
// Each grant waits MEM_LAT cycles, streams BURST beats, then pulses done for one cycle.
module mem_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  parameter int BURST   = 8,
  parameter int MEM_LAT = 100
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              r0_req,
  input  logic                              r0_we,
  input  logic [ADDR_W-1:0]                 r0_addr,
  input  logic [DATA_W-1:0]                 r0_wdata,
  output logic                              r0_gnt,
  output logic                              r0_rvalid,
  output logic                              r0_done,
  input  logic                              r1_req,
  input  logic                              r1_we,
  input  logic [ADDR_W-1:0]                 r1_addr,
  input  logic [DATA_W-1:0]                 r1_wdata,
  output logic                              r1_gnt,
  output logic                              r1_rvalid,
  output logic                              r1_done,
  output logic [$clog2(BURST)-1:0]          beat,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [ADDR_W+$clog2(BURST)-1:0]   mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata
);
  localparam int BW = $clog2(BURST);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic r_win, r_last, r_we, r_rv;
  logic w_any, w_pick, w_busy;
  assign w_any  = r0_req | r1_req;
  // a tie goes to whoever did not win last time
  assign w_pick = (r0_req & r1_req) ? ~r_last : r1_req;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? WAIT : IDLE;
      WAIT:    w_next = (r_cnt == '0) ? XFER : WAIT;
      XFER:    w_next = (r_beat == BW'(BURST - 1)) ? DONE : XFER;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_cnt  <= '0;
      r_beat <= '0;
      r_addr <= '0;
      r_win  <= 1'b0;
      r_last <= 1'b1;
      r_we   <= 1'b0;
      r_rv   <= 1'b0;
    end else begin
      r_rv <= (r_state == XFER) & ~r_we;
      if (r_state == IDLE && w_any) begin
        r_win  <= w_pick;
        r_last <= w_pick;
        r_we   <= w_pick ? r1_we : r0_we;
        r_addr <= w_pick ? r1_addr : r0_addr;
        r_cnt  <= CW'(MEM_LAT - 1);
      end
      if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      // wraps back to zero on the last beat
      if (r_state == XFER) r_beat <= r_beat + 1'b1;
    end
  assign w_busy    = r_state != IDLE;
  assign r0_gnt    = w_busy & ~r_win;
  assign r1_gnt    = w_busy & r_win;
  assign r0_rvalid = r_rv & ~r_win;
  assign r1_rvalid = r_rv & r_win;
  assign r0_done   = (r_state == DONE) & ~r_win;
  assign r1_done   = (r_state == DONE) & r_win;
  assign beat      = r_beat;
  assign rdata     = mem_rdata;
  assign mem_en    = r_state == XFER;
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = {r_addr, r_beat};
  assign mem_wdata = r_win ? r1_wdata : r0_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic against a phase-based transaction model.
module tb_mem_arbiter;
  localparam int AW = 14, DW = 16, BURST = 8, LAT = 4, BW = 3;
  logic CLK = 1'b0, RESET = 1'b0;
  logic r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata, r1_wdata, rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done, mem_en, mem_we;
  logic [BW-1:0] beat;
  logic [AW+BW-1:0] mem_addr;
  int errors = 0, checks = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_done(r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_done(r1_done),
    .beat(beat), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 CLK = ~CLK;

  // requesters present their write beat for the shared beat index
  assign r0_wdata = 16'h5000 + 16'(beat);
  assign r1_wdata = 16'hA000 + 16'(beat);

  function automatic logic [DW-1:0] mem_f(input logic [AW+BW-1:0] a);
    return DW'(a * 17'd7) ^ 16'h3C5A;
  endfunction

  always @(posedge CLK) mem_rdata <= (mem_en && !mem_we) ? mem_f(mem_addr) : '0;

  // model: a transaction is a phase count from the grant edge
  logic m_busy = 1'b0, m_win = 1'b0, m_last = 1'b1, m_we = 1'b0, m_pick;
  int m_ph = 0;
  logic [AW-1:0] m_addr = '0;
  assign m_pick = (r0_req && r1_req) ? !m_last : r1_req;
  always @(posedge CLK or negedge RESET)
    if (!RESET) begin
      m_busy <= 1'b0;
      m_last <= 1'b1;
      m_ph   <= 0;
    end else if (m_busy) begin
      m_ph <= m_ph + 1;
      if (m_ph == LAT + BURST) m_busy <= 1'b0;
    end else if (r0_req || r1_req) begin
      m_win  <= m_pick;
      m_last <= m_pick;
      m_we   <= m_pick ? r1_we : r0_we;
      m_addr <= m_pick ? r1_addr : r0_addr;
      m_busy <= 1'b1;
      m_ph   <= 0;
    end

  logic e_en, e_rv, e_done;
  logic [BW-1:0] e_beat;
  assign e_en   = m_busy && m_ph >= LAT && m_ph < LAT + BURST;
  assign e_rv   = m_busy && !m_we && m_ph >= LAT + 1 && m_ph <= LAT + BURST;
  assign e_done = m_busy && m_ph == LAT + BURST;
  assign e_beat = e_en ? BW'(m_ph - LAT) : '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    chk("r0_gnt", 32'(r0_gnt), 32'(m_busy && !m_win));
    chk("r1_gnt", 32'(r1_gnt), 32'(m_busy && m_win));
    chk("r0_rvalid", 32'(r0_rvalid), 32'(e_rv && !m_win));
    chk("r1_rvalid", 32'(r1_rvalid), 32'(e_rv && m_win));
    chk("r0_done", 32'(r0_done), 32'(e_done && !m_win));
    chk("r1_done", 32'(r1_done), 32'(e_done && m_win));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_en && m_we));
    chk("beat", 32'(beat), 32'(e_beat));
    if (e_en) chk("mem_addr", 32'(mem_addr), 32'({m_addr, e_beat}));
    if (e_en && m_we) chk("mem_wdata", 32'(mem_wdata), 32'((m_win ? 16'hA000 : 16'h5000) + 16'(e_beat)));
    if (e_rv) chk("rdata", 32'(rdata), 32'(mem_f({m_addr, BW'(m_ph - LAT - 1)})));
  end

  function automatic logic [8:0] outs();
    return {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_done, r1_done, mem_en, mem_we, |beat};
  endfunction

  task automatic do_reset;
    RESET = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_outs", 32'(outs()), 32'd0);
    #1 RESET = 1'b1;
  endtask

  task automatic single_read;
    int g = -1, ef = -1, el = -1, rf = -1, rl = -1, dc = -1;
    logic [AW+BW-1:0] af = '0, al = '0;
    do_reset();
    r0_we = 1'b0; r0_addr = 14'h012; r0_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (r0_gnt && g < 0) g = k;
      if (mem_en) begin
        if (ef < 0) begin ef = k; af = mem_addr; end
        el = k; al = mem_addr;
      end
      if (r0_rvalid) begin
        if (rf < 0) rf = k;
        rl = k;
      end
      if (r0_done && dc < 0) begin dc = k; #1 r0_req = 1'b0; end
    end
    chk("sr_gnt_cycle", g, 1);
    chk("sr_en_first", ef, 5);
    chk("sr_en_last", el, 12);
    chk("sr_addr_first", 32'(af), 32'h090);
    chk("sr_addr_last", 32'(al), 32'h097);
    chk("sr_rv_first", rf, 6);
    chk("sr_rv_last", rl, 13);
    chk("sr_done_cycle", dc, 13);
  endtask

  task automatic tie_then_rr;
    int g0 = -1, g1 = -1, d0 = -1, d1 = -1, n = 0;
    int w[4] = '{default: -1};
    logic pb = 1'b0;
    do_reset();
    r0_we = 1'b0; r1_we = 1'b0; r0_addr = 14'h0AA; r1_addr = 14'h155;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (r0_gnt && g0 < 0) g0 = k;
      if (r1_gnt && g1 < 0) g1 = k;
      if (r0_done && d0 < 0) begin d0 = k; #1 r0_req = 1'b0; end
      if (r1_done && d1 < 0) begin d1 = k; #1 r1_req = 1'b0; end
    end
    chk("tie_g0", g0, 1);
    chk("tie_d0", d0, 13);
    chk("tie_g1", g1, 15);
    chk("tie_d1", d1, 27);
    @(negedge CLK); #1;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge CLK);
      if ((r0_gnt || r1_gnt) && !pb) begin w[n] = int'(r1_gnt); n++; end
      pb = r0_gnt || r1_gnt;
    end
    #1 r0_req = 1'b0; r1_req = 1'b0;
    chk("rr_count", n, 4);
    for (int i = 0; i < 4; i++) chk("rr_winner", w[i], i % 2);
    repeat (20) @(negedge CLK);
  endtask

  task automatic write_burst;
    int wc = 0;
    logic [DW-1:0] wf = '0, wl = '0;
    logic rv = 1'b0, dn = 1'b0;
    #1 r1_we = 1'b1; r1_addr = 14'(32'h2000 | $urandom_range(0, 255)); r1_req = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (mem_en && mem_we) begin
        if (wc == 0) wf = mem_wdata;
        wl = mem_wdata; wc++;
      end
      if (r1_rvalid) rv = 1'b1;
      if (r1_done && !dn) begin dn = 1'b1; #1 r1_req = 1'b0; end
    end
    chk("wr_beats", wc, 8);
    chk("wr_first", 32'(wf), 32'hA000);
    chk("wr_last", 32'(wl), 32'hA007);
    chk("wr_no_rvalid", 32'(rv), 0);
    chk("wr_done", 32'(dn), 1);
    #1 r1_we = 1'b0;
  endtask

  task automatic reset_mid_xfer;
    logic hit = 1'b0, dn = 1'b0;
    int g = -1, d = -1;
    #1 r0_we = 1'b0; r0_addr = 14'h321; r0_req = 1'b1;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge CLK);
      hit = mem_en && beat == 3'd3;
    end
    chk("rx_reached_beat3", 32'(hit), 1);
    #2 RESET = 1'b0;
    #1 chk("rx_outs_zero", 32'(outs()), 32'd0);
    repeat (2) begin
      @(negedge CLK);
      if (r0_done) dn = 1'b1;
    end
    #1 RESET = 1'b1; r0_req = 1'b0; r1_we = 1'b0; r1_addr = 14'h077; r1_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (r0_done) dn = 1'b1;
      if (r1_gnt && g < 0) g = k;
      if (r1_done && d < 0) begin d = k; #1 r1_req = 1'b0; end
    end
    chk("rx_no_r0_done", 32'(dn), 0);
    chk("rx_r1_gnt", g, 1);
    chk("rx_r1_done", d, 13);
  endtask

  task automatic req_dropped;
    int en = 0;
    logic g = 1'b0, dn = 1'b0;
    #1 r0_we = 1'b0; r0_addr = 14'h1F0; r0_req = 1'b1;
    for (int k = 0; k < 10 && !g; k++) begin
      @(negedge CLK);
      g = r0_gnt;
    end
    chk("rd_granted", 32'(g), 1);
    #1 r0_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (mem_en) en++;
      if (r0_done) dn = 1'b1;
    end
    chk("rd_beats", en, 8);
    chk("rd_done", 32'(dn), 1);
  endtask

  task automatic random_phase;
    for (int k = 0; k < 800; k++) begin
      @(negedge CLK); #1;
      if (r0_done) r0_req = 1'b0;
      else if (r0_gnt) begin
        r0_addr = AW'($urandom); r0_we = 1'($urandom);
        if ($urandom % 16 == 0) r0_req = 1'b0;
      end else if (!r0_req && $urandom % 4 == 0) begin
        r0_req = 1'b1; r0_we = 1'($urandom); r0_addr = AW'($urandom);
      end
      if (r1_done) r1_req = 1'b0;
      else if (r1_gnt) begin
        r1_addr = AW'($urandom); r1_we = 1'($urandom);
        if ($urandom % 16 == 0) r1_req = 1'b0;
      end else if (!r1_req && $urandom % 4 == 0) begin
        r1_req = 1'b1; r1_we = 1'($urandom); r1_addr = AW'($urandom);
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (30) @(negedge CLK);
  endtask

  initial begin
    single_read();
    tie_then_rr();
    write_burst();
    reset_mid_xfer();
    req_dropped();
    random_phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
